// File: rtl/dcache_sa_controller.sv
// dcache_sa_controller: write-back, write-allocate set-associative data cache
// controller with round-robin victim selection and hit/miss counters.
module dcache_sa_controller #(
    parameter int SETS = 16,
    parameter int WAYS = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 27 - IW;
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2, FILLED = 2'd3;

    logic [1:0]                state;
    logic                      replay;
    logic [SETS-1:0][WAYS-1:0] valid, dirty;
    logic [SETS-1:0][PW-1:0]   ptr;
    logic [TW-1:0]             tags [SETS][WAYS];
    logic [255:0]              lines [SETS][WAYS];
    logic [31:0]               hit_cnt, miss_cnt;
    logic [IW-1:0]             idx;
    logic [TW-1:0]             tag;
    logic [2:0]                wsel;
    logic                      req, hit, use_ptr, unused_addr;
    logic [PW-1:0]             hit_way, vic;

    assign idx = cpu_addr_i[4+IW:5];
    assign tag = cpu_addr_i[31:5+IW];
    assign wsel = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign req = cpu_MemRead_i | cpu_MemWrite_i;

    // Descending scan leaves the lowest-numbered invalid way as victim.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        vic = ptr[idx];
        use_ptr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[idx][w] && tags[idx][w] == tag) begin
                hit = 1'b1;
                hit_way = PW'(w);
            end
            if (!valid[idx][w]) begin
                vic = PW'(w);
                use_ptr = 1'b0;
            end
        end
    end

    assign cpu_stall_o = (state != IDLE) || (req && !hit);
    assign cpu_data_o = (state == IDLE && hit && cpu_MemRead_i) ? lines[idx][hit_way][{wsel, 5'b0} +: 32] : '0;
    assign mem_enable_o = state == WRITEBACK || state == ALLOCATE;
    assign mem_write_o = state == WRITEBACK;
    assign mem_addr_o = (state == WRITEBACK) ? {tags[idx][vic], idx, 5'b0} :
                        (state == ALLOCATE) ? {tag, idx, 5'b0} : '0;
    assign mem_data_o = (state == WRITEBACK) ? lines[idx][vic] : '0;
    assign hit_cnt_o = hit_cnt;
    assign miss_cnt_o = miss_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            replay <= 1'b0;
            valid <= '0;
            dirty <= '0;
            ptr <= '0;
            hit_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    if (hit) begin
                        replay <= 1'b0;
                        if (!replay) hit_cnt <= hit_cnt + 32'd1;
                        if (cpu_MemWrite_i) dirty[idx][hit_way] <= 1'b1;
                    end else begin
                        miss_cnt <= miss_cnt + 32'd1;
                        state <= (valid[idx][vic] && dirty[idx][vic]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (mem_ack_i) state <= ALLOCATE;
                ALLOCATE: if (mem_ack_i) begin
                    state <= FILLED;
                    valid[idx][vic] <= 1'b1;
                    dirty[idx][vic] <= 1'b0;
                    if (use_ptr) ptr[idx] <= (WAYS == 1) ? '0 : ptr[idx] + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    replay <= 1'b1;
                end
            endcase
        end
    end

    // Line and tag storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i) begin
            lines[idx][vic] <= mem_data_i;
            tags[idx][vic] <= tag;
        end else if (state == IDLE && req && hit && cpu_MemWrite_i)
            lines[idx][hit_way][{wsel, 5'b0} +: 32] <= cpu_data_i;
    end
endmodule

// File: tb/tb_dcache_sa_controller.sv
// tb_dcache_sa_controller: directed vector table, multi-cycle corner cases and
// randomized accesses checked against a set/way cache model and a line memory.
module tb_dcache_sa_controller;
    localparam int SETS = 16;
    localparam int WAYS = 2;
    localparam int IW = 4;
    localparam int NV = 17;

    logic         clk_i = 1'b0, rst_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0, cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  hit_cnt_o, miss_cnt_o;
    int errors = 0, checks = 0;

    dcache_sa_controller #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [31:0]  m_tag [SETS][WAYS];
    logic [255:0] m_line [SETS][WAYS];
    int           m_ptr [SETS];
    logic [31:0]  m_hit, m_miss;
    logic [255:0] mem [bit [31:0]];

    typedef struct {
        bit rst; bit w; bit r; logic [31:0] a; logic [31:0] d; int dly;
        bit hit; bit wb; logic [31:0] wb_addr; int wb_word; logic [31:0] wb_val;
        logic [31:0] rf; bit chk_rd; logic [31:0] rd;
    } vec_t;
    vec_t vt [NV];

    function automatic vec_t mk(bit rst, bit w, bit r, logic [31:0] a, logic [31:0] d, int dly,
                                bit hit, bit wb, logic [31:0] wb_addr, int wb_word, logic [31:0] wb_val,
                                logic [31:0] rf, bit chk_rd, logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.w = w; v.r = r; v.a = a; v.d = d; v.dly = dly;
        v.hit = hit; v.wb = wb; v.wb_addr = wb_addr; v.wb_word = wb_word; v.wb_val = wb_val;
        v.rf = rf; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = la * 32'd3 + 32'(i) * 32'h0101_0101 + 32'h5A00_0000;
        return l;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hit = '0;
        m_miss = '0;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // One CPU access: predicts with the model, services memory with ack after dly waits.
    task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input int dly,
                          output bit o_hit, output bit o_wb, output logic [31:0] o_wb_addr,
                          output logic [255:0] o_wb_line, output logic [31:0] o_rf_addr, output logic [31:0] o_rdata);
        int s, hw, v, cyc, waitc, exp_cyc, wd;
        logic [31:0] tg, exp_wb_addr, exp_rf_addr, exp_rdata;
        logic [255:0] exp_wb_line;
        bit exp_hit, exp_wb;
        s = int'((a >> 5) % 32'(SETS));
        tg = a >> (5 + IW);
        wd = int'(a[4:2]);
        hw = -1;
        for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == tg) hw = i;
        exp_hit = hw >= 0;
        exp_wb = 1'b0;
        exp_wb_addr = '0;
        exp_wb_line = '0;
        exp_rf_addr = '0;
        exp_rdata = '0;
        if (!exp_hit) begin
            m_miss = m_miss + 32'd1;
            v = -1;
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
            if (v < 0) begin
                v = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            if (m_valid[s][v] && m_dirty[s][v]) begin
                exp_wb = 1'b1;
                exp_wb_addr = (m_tag[s][v] << (5 + IW)) | (32'(s) << 5);
                exp_wb_line = m_line[s][v];
                mem[exp_wb_addr] = m_line[s][v];
            end
            exp_rf_addr = a & ~32'h1F;
            m_line[s][v] = mem_line(exp_rf_addr);
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v] = tg;
            hw = v;
        end else m_hit = m_hit + 32'd1;
        if (w) begin
            m_line[s][hw][wd*32 +: 32] = d;
            m_dirty[s][hw] = 1'b1;
        end else exp_rdata = m_line[s][hw][wd*32 +: 32];
        exp_cyc = exp_hit ? 0 : 2 + (dly + 1) * (exp_wb ? 2 : 1);

        cpu_MemWrite_i = w;
        cpu_MemRead_i = r;
        cpu_addr_i = a;
        cpu_data_i = d;
        #1;
        o_hit = !cpu_stall_o;
        o_wb = 1'b0;
        o_wb_addr = '0;
        o_wb_line = '0;
        o_rf_addr = '0;
        cyc = 0;
        waitc = 0;
        while (cpu_stall_o && cyc < 100) begin
            if (mem_enable_o) begin
                if (mem_write_o) begin
                    o_wb = 1'b1;
                    o_wb_addr = mem_addr_o;
                    o_wb_line = mem_data_o;
                end else begin
                    o_rf_addr = mem_addr_o;
                    mem_data_i = mem_line(mem_addr_o);
                end
                if (waitc == dly) begin
                    mem_ack_i = 1'b1;
                    waitc = 0;
                end else waitc++;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            #1;
            cyc++;
        end
        o_rdata = cpu_data_o;
        check($sformatf("stall_cycles@%0h", a), cyc, exp_cyc);
        check($sformatf("hit@%0h", a), o_hit, exp_hit);
        check($sformatf("writeback@%0h", a), o_wb, exp_wb);
        if (exp_wb) begin
            check($sformatf("wb_addr@%0h", a), o_wb_addr, exp_wb_addr);
            check($sformatf("wb_line@%0h", a), o_wb_line, exp_wb_line);
        end
        if (!exp_hit) check($sformatf("refill_addr@%0h", a), o_rf_addr, exp_rf_addr);
        if (!w) check($sformatf("load_data@%0h", a), o_rdata, exp_rdata);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check($sformatf("hit_cnt@%0h", a), hit_cnt_o, m_hit);
        check($sformatf("miss_cnt@%0h", a), miss_cnt_o, m_miss);
    endtask

    initial begin
        bit oh, owb;
        logic [31:0] owa, orf, ord, ra;
        logic [255:0] owl, l40;
        int op;
        l40 = mem_line(32'h40);
        l40[31:0] = 32'h1111_2222;
        mem[32'h40] = l40;
        //          rst w  r  addr       data          dly hit wb wb_addr  wd wb_val        refill     chk rd
        vt[0]  = mk(1, 0, 1, 32'h040, 32'h0,         2, 0, 0, 32'h0,   0, 32'h0,         32'h040, 1, 32'h1111_2222);
        vt[1]  = mk(0, 0, 1, 32'h040, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h1111_2222);
        vt[2]  = mk(1, 0, 1, 32'h000, 32'h0,         1, 0, 0, 32'h0,   0, 32'h0,         32'h000, 0, 32'h0);
        vt[3]  = mk(0, 0, 1, 32'h200, 32'h0,         0, 0, 0, 32'h0,   0, 32'h0,         32'h200, 0, 32'h0);
        vt[4]  = mk(0, 0, 1, 32'h000, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   0, 32'h0);
        vt[5]  = mk(0, 0, 1, 32'h200, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   0, 32'h0);
        vt[6]  = mk(1, 1, 0, 32'h000, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,   0, 32'h0,         32'h000, 0, 32'h0);
        vt[7]  = mk(0, 0, 1, 32'h200, 32'h0,         3, 0, 0, 32'h0,   0, 32'h0,         32'h200, 0, 32'h0);
        vt[8]  = mk(0, 0, 1, 32'h400, 32'h0,         0, 0, 1, 32'h000, 0, 32'hDEAD_BEEF, 32'h400, 0, 32'h0);
        vt[9]  = mk(0, 0, 1, 32'h200, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   0, 32'h0);
        vt[10] = mk(0, 0, 1, 32'h000, 32'h0,         1, 0, 0, 32'h0,   0, 32'h0,         32'h000, 1, 32'hDEAD_BEEF);
        vt[11] = mk(1, 1, 0, 32'h084, 32'h1234_5678, 2, 0, 0, 32'h0,   0, 32'h0,         32'h080, 0, 32'h0);
        vt[12] = mk(0, 0, 1, 32'h084, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h1234_5678);
        vt[13] = mk(0, 0, 1, 32'h284, 32'h0,         1, 0, 0, 32'h0,   0, 32'h0,         32'h280, 0, 32'h0);
        vt[14] = mk(0, 0, 1, 32'h484, 32'h0,         0, 0, 1, 32'h080, 1, 32'h1234_5678, 32'h480, 0, 32'h0);
        vt[15] = mk(0, 1, 1, 32'h488, 32'hCAFE_F00D, 0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   0, 32'h0);
        vt[16] = mk(0, 0, 1, 32'h488, 32'h0,         0, 1, 0, 32'h0,   0, 32'h0,         32'h0,   1, 32'hCAFE_F00D);

        do_reset();
        #1;
        check("rst_hit_cnt", hit_cnt_o, 32'h0);
        check("rst_miss_cnt", miss_cnt_o, 32'h0);
        check("rst_stall_idle", cpu_stall_o, 1'b0);
        check("rst_mem_enable", mem_enable_o, 1'b0);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst) do_reset();
            access(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].dly, oh, owb, owa, owl, orf, ord);
            check($sformatf("v%0d_hit", i), oh, vt[i].hit);
            check($sformatf("v%0d_wb", i), owb, vt[i].wb);
            if (vt[i].wb) begin
                check($sformatf("v%0d_wb_addr", i), owa, vt[i].wb_addr);
                check($sformatf("v%0d_wb_word", i), owl[vt[i].wb_word*32 +: 32], vt[i].wb_val);
            end
            if (!vt[i].hit) check($sformatf("v%0d_refill", i), orf, vt[i].rf);
            if (vt[i].chk_rd) check($sformatf("v%0d_rdata", i), ord, vt[i].rd);
            if (i == 5) begin
                check("assoc_hits", hit_cnt_o, 32'd2);
                check("assoc_misses", miss_cnt_o, 32'd2);
            end
        end

        // Long ALLOCATE wait, then asynchronous reset mid-transaction.
        do_reset();
        @(negedge clk_i);
        cpu_MemRead_i = 1'b1;
        cpu_addr_i = 32'h40;
        #1;
        check("dly_idle_stall", cpu_stall_o, 1'b1);
        check("dly_idle_noreq", mem_enable_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("dly_hold%0d", k), {mem_enable_o, mem_write_o, mem_addr_o}, {1'b1, 1'b0, 32'h40});
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
        end
        check("dly_miss_before_rst", miss_cnt_o, 32'd1);
        rst_i = 1'b0;
        #1;
        check("arst_mem_enable", mem_enable_o, 1'b0);
        check("arst_mem_write", mem_write_o, 1'b0);
        check("arst_mem_addr", mem_addr_o, 32'h0);
        check("arst_mem_data", mem_data_o, 256'h0);
        check("arst_cpu_data", cpu_data_o, 32'h0);
        check("arst_hit_cnt", hit_cnt_o, 32'h0);
        check("arst_miss_cnt", miss_cnt_o, 32'h0);
        check("arst_stall_req", cpu_stall_o, 1'b1);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        access(1'b0, 1'b1, 32'h40, 32'h0, 1, oh, owb, owa, owl, orf, ord);
        check("rerun_misses", oh, 1'b0);

        // Counter wrap from all-ones.
        @(negedge clk_i);
        force dut.hit_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hit_cnt;
        #1;
        check("wrap_preload", hit_cnt_o, 32'hFFFF_FFFF);
        m_hit = 32'hFFFF_FFFF;
        access(1'b0, 1'b1, 32'h40, 32'h0, 0, oh, owb, owa, owl, orf, ord);
        check("wrap_is_hit", oh, 1'b1);
        check("wrap_zero", hit_cnt_o, 32'h0);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            ra = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            op = int'($urandom_range(0, 3));
            access(op >= 2, op != 2, ra, $urandom, int'($urandom_range(0, 3)), oh, owb, owa, owl, orf, ord);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_sa_controller.md
# dcache_sa_controller

Parametrised write-back, write-allocate, set-associative data cache controller sitting in the MEM stage between the EX/MEM pipeline register and the 256-bit line-wide main memory. It replaces the direct-mapped controller with configurable set count and associativity, deterministic victim selection and hit/miss performance counters. It asserts `cpu_stall_o` combinationally on a miss, and the whole pipeline freezes on that signal.

## Interface
- `SETS`, 16: number of sets; power of two, 2..256. Index width `IW = log2(SETS)`.
- `WAYS`, 2: associativity; power of two, 1..8.
- Line is fixed at 256 bits (32 bytes): offset = addr[4:0], word select = addr[4:2], index = addr[4+IW:5], tag = addr[31:5+IW].
- `clk_i` in 1: clock, all state updates on rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `cpu_addr_i` in 32: byte address from EX/MEM ALU result; word-aligned.
- `cpu_data_i` in 32: store data.
- `cpu_MemRead_i` in 1: load request, level, held while stalled.
- `cpu_MemWrite_i` in 1: store request, level, held while stalled.
- `cpu_data_o` out 32: load data, valid in the cycle `cpu_stall_o`=0 with `cpu_MemRead_i`=1.
- `cpu_stall_o` out 1: freeze the pipeline.
- `mem_data_i` in 256: refill line.
- `mem_ack_i` in 1: one-cycle completion pulse from memory.
- `mem_data_o` out 256: write-back line.
- `mem_addr_o` out 32: line-aligned memory address (bits [4:0] = 0).
- `mem_enable_o` out 1: memory request.
- `mem_write_o` out 1: 1 = write-back, 0 = refill.
- `hit_cnt_o` out 32: completed accesses that hit on first lookup; wraps modulo 2^32.
- `miss_cnt_o` out 32: accesses that missed; wraps modulo 2^32.

## Operation
- Storage per set/way: valid, dirty, tag, 256-bit line. Per set: a round-robin victim pointer of log2(WAYS) bits (zero bits when WAYS=1).
- Request = `cpu_MemRead_i | cpu_MemWrite_i`. If both are asserted, the request is treated as a store.
- Hit: a way has valid=1 and a matching tag. Hit way data is word-muxed to `cpu_data_o` combinationally. A store hit writes the word and sets dirty=1 at the next edge.
- Victim: the lowest-numbered invalid way. If no way is invalid, the way at the set's pointer. The pointer advances by 1, modulo WAYS, only on a fill that used it.
- FSM states: IDLE, WRITEBACK, ALLOCATE, FILLED.
  - IDLE + request + miss: `cpu_stall_o`=1 combinationally and `miss_cnt_o`+1. Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line. Holds until `mem_ack_i`, then goes to ALLOCATE.
  - ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={req tag, index, 5'b0}. On `mem_ack_i`, the edge writes `mem_data_i` into the victim way (valid=1, dirty=0, tag=req tag) and the state moves to FILLED.
  - FILLED: `cpu_stall_o`=1 and no memory request. Next state is IDLE with a "replay" flag set.
  - IDLE + replay: the access hits, is serviced as a normal hit (store sets dirty), is not counted in `hit_cnt_o`, and clears the replay flag.
- IDLE + request + hit with no replay flag: `hit_cnt_o`+1 at the edge.
- Outside WRITEBACK/ALLOCATE: `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- `cpu_stall_o`=1 in WRITEBACK, ALLOCATE, FILLED, and in IDLE on a miss; otherwise 0.

## Timing
- Hit latency: 0 stall cycles.
- Clean miss: stall for 1 (IDLE miss) + ack wait + 1 (FILLED) cycles, then 1 serviced cycle.
- Dirty miss: adds one write-back ack wait.
- Memory side: request signals stay constant from entry to a state until the edge where `mem_ack_i`=1. `mem_ack_i` outside WRITEBACK/ALLOCATE is ignored. An ack arriving the first cycle of a state is legal.
- Reset (asynchronous, any state, including mid-transaction):
  - state returns to IDLE and the replay flag clears;
  - all valid, dirty and pointer bits clear;
  - counters go to 0;
  - `mem_enable_o` drops immediately;
  - all outputs are 0 except `cpu_stall_o`, which follows the IDLE miss rule (1 if a request is present, since the cache is empty).
- Counter wrap: 0xFFFFFFFF + 1 → 0.

## Test plan
- **Cold load miss then hit.** SETS=16, WAYS=2. Load 0x0000_0040 with memory returning a line whose word 0 = 0x1111_2222.
  - Stall covers IDLE-miss, ALLOCATE, FILLED; one ALLOCATE request at addr 0x40.
  - Load is serviced with `cpu_data_o`=0x1111_2222.
  - `miss_cnt_o`=1, `hit_cnt_o`=0.
  - A second load of 0x40 has no stall and `hit_cnt_o`=1.
- **Associativity.** Loads of 0x000, 0x200, 0x000, 0x200 (same set 0, different tags).
  - Exactly 2 refills, no write-backs.
  - Final counts: `miss_cnt_o`=2, `hit_cnt_o`=2.
- **Dirty eviction.** Store 0xDEAD_BEEF to 0x000, load 0x200, then load 0x400.
  - The 0x400 miss issues WRITEBACK to addr 0x000 with `mem_data_o`[31:0]=0xDEAD_BEEF, then ALLOCATE at 0x400.
  - The round-robin pointer evicted way 0.
- **Store miss (write-allocate).** Store 0x1234_5678 to 0x084 on an empty cache.
  - Refill at 0x080.
  - A later load of 0x084 returns 0x1234_5678 with no stall.
  - The eviction of that line writes back word 1 = 0x1234_5678.
- **Delayed ack and reset mid-operation.** Hold `mem_ack_i` low for 10 cycles in ALLOCATE, checking that request signals stay constant. Then assert `rst_i`=0.
  - `mem_enable_o`=0 immediately; counters are 0.
  - The next load of the same address misses again.
- **Counter wrap.** Force `hit_cnt_o` to 0xFFFF_FFFF, then perform one hit → `hit_cnt_o`=0.
